// File: rtl/audio_stream_ctrl_pkg.sv
// Shared definitions for the audio flash streamer: register map, CSR bits, FSM states.
package audio_stream_ctrl_pkg;

    localparam logic [3:0] REG_CSR    = 4'd0;
    localparam logic [3:0] REG_START  = 4'd1;
    localparam logic [3:0] REG_END    = 4'd2;
    localparam logic [3:0] REG_STATUS = 4'd3;

    localparam int CSR_RUN      = 0;
    localparam int CSR_LOOP     = 1;
    localparam int CSR_BUSY     = 2;
    localparam int CSR_UNDERRUN = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_e;

endpackage

// File: rtl/audio_stream_ctrl_level.sv
// FIFO occupancy tracker; refill_ok says a full burst still fits downstream.
module stream_level_cnt #(
    parameter int BURST      = 128,
    parameter int FIFO_DEPTH = 512,
    parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [LW-1:0] level,
    output logic          refill_ok
);

    logic [LW-1:0] level_q, level_d;

    always_comb begin
        level_d = level_q;
        if (inc && !dec) begin
            level_d = level_q + LW'(1);
        end else if (dec && !inc) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level     = level_q;
    assign refill_ok = (level_q <= LW'(FIFO_DEPTH - BURST));

endmodule

// File: rtl/audio_stream_ctrl.sv
// Streams a flash region into the audio FIFO in bursts, with a Wishbone control/status port.
module audio_stream_ctrl
    import audio_stream_ctrl_pkg::*;
#(
    parameter int BURST      = 128,
    parameter int FIFO_DEPTH = 512,
    parameter int AW         = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    wb_addr,
    input  logic [31:0]   wb_wdata,
    output logic [31:0]   wb_rdata,
    input  logic          wb_we,
    input  logic          wb_cyc,
    output logic          wb_ack,
    output logic [AW-1:0] fr_addr,
    output logic [15:0]   fr_len,
    output logic          fr_go,
    input  logic          fr_rdy,
    input  logic          fr_valid,
    input  logic          af_empty,
    output logic          af_rena,
    input  logic          snd_ack,
    output logic          snd_mute
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(BURST) + 1;
    localparam logic [AW-1:0] BURST_A = AW'(BURST);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    state_e        state_q, state_d;
    logic          run_q, run_d, loop_q, loop_d, underrun_q, underrun_d;
    logic [AW-1:0] start_q, start_d, end_q, end_d, cur_q, cur_d;
    logic [AW-1:0] fr_addr_q, fr_addr_d;
    logic [15:0]   fr_len_q, fr_len_d;
    logic          fr_go_q, fr_go_d, wb_ack_q, wb_ack_d;
    logic [31:0]   wb_rdata_q, wb_rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] level;
    logic          refill_ok, busy, wb_acc, wb_wr;
    logic [AW-1:0] remain, len_m1;
    logic          wdata_unused;

    stream_level_cnt #(
        .BURST      (BURST),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LW         (LW)
    ) u_level (
        .clk       (clk),
        .rst       (rst),
        .inc       (fr_valid),
        .dec       (af_rena),
        .level     (level),
        .refill_ok (refill_ok)
    );

    assign af_rena  = snd_ack & ~af_empty & run_q;
    assign snd_mute = ~run_q | af_empty;
    assign busy     = (state_q != ST_IDLE);
    assign wb_acc   = wb_cyc & ~wb_ack_q;
    assign wb_wr    = wb_acc & wb_we;
    assign remain   = end_q - cur_q;
    assign len_m1   = (remain < BURST_A) ? remain - ONE_A : BURST_A - ONE_A;

    generate
        if (AW < 32) begin : g_wdata_hi
            assign wdata_unused = ^wb_wdata[31:AW];
        end else begin : g_wdata_full
            assign wdata_unused = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        loop_d     = loop_q;
        underrun_d = underrun_q;
        start_d    = start_q;
        end_d      = end_q;
        cur_d      = cur_q;
        fr_addr_d  = fr_addr_q;
        fr_len_d   = fr_len_q;
        cnt_d      = cnt_q;
        fr_go_d    = 1'b0;
        wb_ack_d   = wb_acc;
        wb_rdata_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (run_q) begin
                    // cur >= end also covers an inverted region: nothing to read
                    if (cur_q >= end_q) begin
                        if (loop_q) begin
                            if (start_q < end_q) cur_d = start_q;
                        end else begin
                            run_d = 1'b0;
                        end
                    end else if (fr_rdy && refill_ok) begin
                        state_d   = ST_REQ;
                        fr_go_d   = 1'b1;
                        fr_addr_d = cur_q;
                        fr_len_d  = 16'(len_m1);
                    end
                end
            end
            ST_REQ: begin
                cnt_d   = CW'(fr_len_q) + CW'(1);
                state_d = ST_XFER;
            end
            ST_XFER: begin
                if (fr_valid) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        cur_d   = cur_q + AW'(fr_len_q) + ONE_A;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Register writes land after the FSM so software wins any same-cycle conflict.
        if (wb_wr) begin
            case (wb_addr)
                REG_CSR: begin
                    if (wb_wdata[CSR_RUN] && !run_q) cur_d = start_q;
                    run_d  = wb_wdata[CSR_RUN];
                    loop_d = wb_wdata[CSR_LOOP];
                    if (wb_wdata[CSR_UNDERRUN]) underrun_d = 1'b0;
                end
                REG_START: start_d = wb_wdata[AW-1:0];
                REG_END:   end_d   = wb_wdata[AW-1:0];
                default: ;
            endcase
        end

        if (snd_ack && run_q && af_empty) underrun_d = 1'b1;

        if (wb_acc && !wb_we) begin
            case (wb_addr)
                REG_CSR: begin
                    wb_rdata_d[CSR_RUN]      = run_q;
                    wb_rdata_d[CSR_LOOP]     = loop_q;
                    wb_rdata_d[CSR_BUSY]     = busy;
                    wb_rdata_d[CSR_UNDERRUN] = underrun_q;
                end
                REG_START: wb_rdata_d[AW-1:0] = start_q;
                REG_END:   wb_rdata_d[AW-1:0] = end_q;
                REG_STATUS: begin
                    wb_rdata_d[AW-1:0] = cur_q;
                    wb_rdata_d[31:24]  = 8'(level >> 2);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            run_q      <= 1'b0;
            loop_q     <= 1'b0;
            underrun_q <= 1'b0;
            start_q    <= '0;
            end_q      <= '0;
            cur_q      <= '0;
            fr_addr_q  <= '0;
            fr_len_q   <= '0;
            cnt_q      <= '0;
            fr_go_q    <= 1'b0;
            wb_ack_q   <= 1'b0;
            wb_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            loop_q     <= loop_d;
            underrun_q <= underrun_d;
            start_q    <= start_d;
            end_q      <= end_d;
            cur_q      <= cur_d;
            fr_addr_q  <= fr_addr_d;
            fr_len_q   <= fr_len_d;
            cnt_q      <= cnt_d;
            fr_go_q    <= fr_go_d;
            wb_ack_q   <= wb_ack_d;
            wb_rdata_q <= wb_rdata_d;
        end
    end

    assign fr_go    = fr_go_q;
    assign fr_addr  = fr_addr_q;
    assign fr_len   = fr_len_q;
    assign wb_ack   = wb_ack_q;
    assign wb_rdata = wb_rdata_q;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Directed + randomized bench: models the flash reader, FIFO and S/PDIF consumer.
module tb_audio_stream_ctrl;
    import audio_stream_ctrl_pkg::*;

    localparam int AW = 24;
    localparam int BURST = 128;
    localparam int FIFO_DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    wb_addr = '0;
    logic [31:0]   wb_wdata = '0;
    logic [31:0]   wb_rdata;
    logic          wb_we = 1'b0, wb_cyc = 1'b0, wb_ack;
    logic [AW-1:0] fr_addr;
    logic [15:0]   fr_len;
    logic          fr_go, fr_rdy, fr_valid, af_rena, snd_mute;
    logic          af_empty = 1'b1, snd_ack = 1'b0;

    int  ncmp = 0, nfail = 0;
    int  fifo_cnt = 0, fifo_next = 0, max_fifo = 0, tot_bytes = 0;
    int  rd_left = 0, cyc = 0, snd_period = 0;
    bit  snd_force = 1'b0, rd_stall = 1'b0;
    logic [AW-1:0] go_addr[$];
    logic [15:0]   go_len[$];

    audio_stream_ctrl #(.BURST(BURST), .FIFO_DEPTH(FIFO_DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
        .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
        .fr_addr(fr_addr), .fr_len(fr_len), .fr_go(fr_go), .fr_rdy(fr_rdy),
        .fr_valid(fr_valid), .af_empty(af_empty), .af_rena(af_rena),
        .snd_ack(snd_ack), .snd_mute(snd_mute)
    );

    always #5 clk = ~clk;

    // Observer: FIFO occupancy model, burst request log, byte count.
    initial forever begin
        @(negedge clk);
        fifo_next = rst ? 0 : fifo_cnt + (fr_valid ? 1 : 0) - (af_rena ? 1 : 0);
        if (fr_valid && !rst) tot_bytes++;
        if (fr_go) begin
            go_addr.push_back(fr_addr);
            go_len.push_back(fr_len);
        end
        if (fifo_cnt > max_fifo) max_fifo = fifo_cnt;
    end

    // FIFO flags and sample consumer.
    initial forever begin
        @(posedge clk);
        #2;
        fifo_cnt = fifo_next;
        af_empty = (fifo_cnt == 0);
        snd_ack  = snd_force || (snd_period != 0 && (cyc % snd_period) == 0);
        cyc++;
    end

    // Flash reader: answers each go with len+1 bytes at a random rate.
    initial begin
        fr_rdy   = 1'b1;
        fr_valid = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            fr_valid = 1'b0;
            if (rst) rd_left = 0;
            else if (fr_go) rd_left = int'(fr_len) + 1;
            else if (rd_left > 0 && $urandom_range(0, 3) != 0) begin
                fr_valid = 1'b1;
                rd_left--;
            end
            fr_rdy = (rd_left == 0) && !rd_stall;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic [3:0] a, input logic we, input logic [31:0] d,
                           output logic [31:0] rd, output logic ack);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_we = we; wb_addr = a; wb_wdata = d;
        @(posedge clk); #1;
        ack = wb_ack;
        rd  = wb_rdata;
        wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic ack;
        wb_xfer(a, 1'b1, d, r, ack);
        chk("wb_wr_ack", {31'd0, ack}, 32'd1);
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic ack;
        wb_xfer(a, 1'b0, 32'd0, r, ack);
        chk(tag, r, exp);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic start_region(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [31:0] csr);
        wb_wr(REG_START, 32'(s));
        wb_wr(REG_END, 32'(e));
        wb_wr(REG_CSR, csr);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] r;
        logic ack;
        bit ok = 1'b0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            wb_xfer(REG_CSR, 1'b0, 32'd0, r, ack);
            ok = (r[CSR_RUN] == 1'b0) && (r[CSR_BUSY] == 1'b0);
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    // Expected requests: walk the region in BURST steps, last one clipped at end.
    task automatic check_gos(input string tag, input int base, input logic [AW-1:0] s, input logic [AW-1:0] e);
        longint a = longint'(s);
        int n = 0;
        int l;
        while (a < longint'(e)) begin
            l = (longint'(e) - a < BURST) ? int'(longint'(e) - a) : BURST;
            chk({tag, "_addr"}, (base + n < go_addr.size()) ? 32'(go_addr[base + n]) : 32'hFFFF_FFFF, 32'(a));
            chk({tag, "_len"},  (base + n < go_len.size())  ? 32'(go_len[base + n])  : 32'hFFFF_FFFF, 32'(l - 1));
            a += l;
            n++;
        end
        chk({tag, "_n"}, 32'(go_addr.size() - base), 32'(n));
    endtask

    initial begin
        int base, b0, n;
        bit ok;
        logic [AW-1:0] s, e;
        logic [31:0] r;
        logic ack;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_go", {31'd0, fr_go}, 32'd0);
        chk("rst_addr", 32'(fr_addr), 32'd0);
        chk("rst_len", 32'(fr_len), 32'd0);
        chk("rst_rena", {31'd0, af_rena}, 32'd0);
        chk("rst_mute", {31'd0, snd_mute}, 32'd1);
        chk("rst_ack", {31'd0, wb_ack}, 32'd0);
        chk("rst_rdata", wb_rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        chk_reg("rst_csr", REG_CSR, 32'd0);
        chk_reg("rst_status", REG_STATUS, 32'd0);
        chk_reg("rst_end", REG_END, 32'd0);

        // Basic fill: four full bursts, last one admitted at level 384
        base = go_addr.size();
        start_region(24'h800000, 24'h800200, 32'h1);
        chk_reg("start_rb", REG_START, 32'h0080_0000);
        wait_idle("fill_done");
        check_gos("fill", base, 24'h800000, 24'h800200);
        chk_reg("fill_status", REG_STATUS, 32'h8080_0200);
        chk_reg("fill_csr", REG_CSR, 32'd0);

        // Partial tail
        do_reset();
        base = go_addr.size();
        start_region(24'h800000, 24'h800050, 32'h1);
        wait_idle("tail_done");
        check_gos("tail", base, 24'h800000, 24'h800050);
        chk_reg("tail_status", REG_STATUS, 32'h1480_0050);

        // Random regions with random drain rate
        for (int k = 0; k < 3; k++) begin
            do_reset();
            s = 24'h800000 + 24'($urandom_range(0, 255));
            e = s + 24'($urandom_range(1, 700));
            snd_period = int'($urandom_range(2, 6));
            base = go_addr.size();
            start_region(s, e, 32'h1);
            wait_idle("rnd_done");
            snd_period = 0;
            check_gos("rnd", base, s, e);
            chk_reg("rnd_status", REG_STATUS, {8'(fifo_cnt >> 2), e});
        end

        // Loop with slow drain
        do_reset();
        base = go_addr.size();
        start_region(24'h800000, 24'h800100, 32'h3);
        for (int i = 0; i < 3000 && fifo_cnt < 256; i++) @(posedge clk);
        chk("loop_fill", {31'd0, fifo_cnt >= 256}, 32'd1);
        #1 snd_period = 8;
        @(negedge clk);
        chk("loop_mute", {31'd0, snd_mute}, 32'd0);
        for (int i = 0; i < 20 && !snd_ack; i++) @(negedge clk);
        chk("loop_rena", {31'd0, af_rena}, 32'd1);
        repeat (4000) @(posedge clk);
        n = go_addr.size() - base;
        chk("loop_n", {31'd0, n >= 6}, 32'd1);
        for (int i = 0; i < n; i++) begin
            chk("loop_addr", 32'(go_addr[base + i]), 32'h0080_0000 + 32'((i % 2) * BURST));
            chk("loop_len", 32'(go_len[base + i]), 32'd127);
        end
        chk("loop_max", {31'd0, max_fifo <= FIFO_DEPTH}, 32'd1);
        wb_xfer(REG_CSR, 1'b0, 32'd0, r, ack);
        chk("loop_udr", {31'd0, r[CSR_UNDERRUN]}, 32'd0);
        snd_period = 0;
        wb_wr(REG_CSR, 32'h0);
        wait_idle("loop_stop");

        // Inverted region: looping stays idle, non-looping clears run
        do_reset();
        base = go_addr.size();
        start_region(24'h800100, 24'h800080, 32'h3);
        repeat (100) @(posedge clk);
        chk_reg("inv_csr", REG_CSR, 32'h3);
        chk_reg("inv_status", REG_STATUS, 32'h0080_0100);
        wb_wr(REG_CSR, 32'h0);
        wb_wr(REG_CSR, 32'h1);
        repeat (5) @(posedge clk);
        chk_reg("inv_stop", REG_CSR, 32'h0);
        chk("inv_n", 32'(go_addr.size() - base), 32'd0);

        // Underrun with stalled reader
        do_reset();
        #1 rd_stall = 1'b1;
        start_region(24'h800000, 24'h800100, 32'h1);
        @(posedge clk); #1 snd_force = 1'b1;
        @(negedge clk);
        chk("udr_rena", {31'd0, af_rena}, 32'd0);
        chk("udr_mute", {31'd0, snd_mute}, 32'd1);
        @(posedge clk); #1 snd_force = 1'b0;
        chk_reg("udr_csr", REG_CSR, 32'h9);
        wb_wr(REG_CSR, 32'h8);
        chk_reg("udr_clr", REG_CSR, 32'h0);
        rd_stall = 1'b0;

        // Stop mid-burst: in-flight burst completes and is counted
        do_reset();
        base = go_addr.size();
        b0 = tot_bytes;
        start_region(24'h800000, 24'h800200, 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(posedge clk);
            ok = (tot_bytes - b0 >= 10);
        end
        chk("stop_start", {31'd0, ok}, 32'd1);
        wb_wr(REG_CSR, 32'h0);
        wait_idle("stop_idle");
        repeat (50) @(posedge clk);
        chk("stop_n", 32'(go_addr.size() - base), 32'd1);
        chk("stop_bytes", 32'(tot_bytes - b0), 32'd128);
        chk_reg("stop_status", REG_STATUS, 32'h2080_0080);
        @(posedge clk); #1 snd_force = 1'b1;
        @(negedge clk);
        chk("stop_rena", {31'd0, af_rena}, 32'd0);
        chk("stop_mute", {31'd0, snd_mute}, 32'd1);
        @(posedge clk); #1 snd_force = 1'b0;

        // Reset mid-transfer
        do_reset();
        b0 = tot_bytes;
        start_region(24'h800000, 24'h800200, 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(posedge clk);
            ok = (tot_bytes - b0 >= 5);
        end
        chk("xrst_start", {31'd0, ok}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        base = go_addr.size();
        @(negedge clk);
        chk("xrst_go", {31'd0, fr_go}, 32'd0);
        chk("xrst_mute", {31'd0, snd_mute}, 32'd1);
        chk_reg("xrst_csr", REG_CSR, 32'h0);
        chk_reg("xrst_status", REG_STATUS, 32'h0);
        repeat (20) @(posedge clk);
        chk("xrst_n", 32'(go_addr.size() - base), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/audio_stream_ctrl.md
Name: audio_stream_ctrl

Overview:
- Sequences the shared SPI flash reader to stream audio samples from a flash region into the audio byte FIFO, keeping the FIFO topped up without overflow.
- Tracks FIFO occupancy, issues fixed-size burst reads, and wraps or stops at the region end.
- Exposes run, loop, region and status through a Wishbone slave on the muacm2wb bus.
- Sits between the Wishbone bridge, spi_flash_reader, fifo_sync_ram and the S/PDIF sample request.

Parameters:
- BURST, 128, maximum bytes per flash read request (power of 2, ≥2).
- FIFO_DEPTH, 512, depth of the downstream FIFO in bytes (power of 2, > BURST).
- AW, 24, flash address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wb_addr  in  4  register index
- wb_wdata  in  32  write data
- wb_rdata  out  32  read data, zero when no ack
- wb_we  in  1  write strobe
- wb_cyc  in  1  cycle/select
- wb_ack  out  1  one-cycle acknowledge
- fr_addr  out  AW  burst start address to flash reader
- fr_len  out  16  burst length minus one
- fr_go  out  1  one-cycle burst request
- fr_rdy  in  1  flash reader idle
- fr_valid  in  1  byte written into FIFO this cycle
- af_empty  in  1  FIFO empty
- af_rena  out  1  FIFO pop
- snd_ack  in  1  S/PDIF consumed a sample
- snd_mute  out  1  high when the output sample must be zero

Behaviour:
- Single clock. Synchronous active-high reset; the clock is named clk and the reset is named rst.
- Reset values:
  - All outputs 0, except snd_mute=1.
  - run=0, loop=0, underrun=0.
  - start=end=cur=0, level=0, state=IDLE.
- Register map (word index):
  - 0 CSR: bit0 run (RW), bit1 loop (RW), bit2 busy (RO), bit3 underrun (sticky, write-1-clear).
  - 1 start address (RW, AW bits).
  - 2 end address, exclusive (RW, AW bits).
  - 3 status (RO): [AW-1:0] cur; [31:24] level>>2.
- Wishbone timing:
  - wb_ack asserts the cycle after wb_cyc and lasts one cycle.
  - A new access is not acked back-to-back: ack is gated by ~wb_ack.
  - Writes take effect on the ack cycle.
  - Writing run 0→1 loads cur←start.
- Level counter (log2(FIFO_DEPTH)+1 bits):
  - +1 on fr_valid & ~af_rena.
  - −1 on af_rena & ~fr_valid.
  - Hold when both or neither.
  - Never exceeds FIFO_DEPTH by construction.
- Sample consumption:
  - af_rena = snd_ack & ~af_empty & run.
  - snd_mute = ~run | af_empty.
  - snd_ack & run & af_empty sets underrun.
- FSM states IDLE, REQ, XFER:
  - IDLE→REQ when run & fr_rdy & (level ≤ FIFO_DEPTH−BURST) & (cur≠end).
  - In IDLE, if run & cur==end: with loop=1 set cur←start; with loop=0 clear run.
  - REQ (one cycle):
    - fr_go=1, fr_addr=cur.
    - fr_len = min(BURST, end−cur) − 1, computed AW-bit unsigned.
    - Load cnt←fr_len+1; go to XFER.
  - XFER: decrement cnt on each fr_valid; when cnt hits 0, cur←cur+burst size, then IDLE.
  - busy = (state≠IDLE).
- Boundaries:
  - end ≤ start is an invalid region: treated as empty, no bursts; with loop=1 it stays idle without thrashing.
  - Clearing run mid-burst: the burst completes in XFER and its bytes are counted; no new REQ is issued; af_rena stops immediately.
  - Writing start/end while busy takes effect on the next REQ.
  - Writing run 1 while busy (already running) does not reload cur.
  - A level equal to FIFO_DEPTH−BURST still permits a request.
  - cur+burst never passes end.
  - A mid-operation reset returns all state to reset values on the next edge; the flash reader is reset by the same rst.

Decomposition:
- Shared package: register index constants (CSR, START, END, STATUS), CSR bit positions, FSM state encoding.
- One natural sub-module, stream_level_cnt: the up/down occupancy counter with the refill-threshold compare. The Wishbone register file stays inline.

Test Plan:
- Basic fill: start=0x800000, end=0x800200, run=1, loop=0, no snd_ack, model reader answers each go with len+1 valid bytes → four go pulses at addrs 0x800000/080/100/180, fr_len=127 each; then run auto-clears, cur=0x800200, level=512.
- Partial tail: start=0x800000, end=0x800050 → single go, fr_len=0x4F; 80 bytes counted; run clears.
- Loop + drain: region 256 bytes, loop=1, snd_ack every 8 cycles → addresses cycle 0x800000, 0x800080, 0x800000…; level never exceeds 512; underrun stays 0.
- Underrun: run=1 with reader stalled (fr_rdy=0), snd_ack pulse → af_rena=0, snd_mute=1, CSR bit3=1; write 0x8 to CSR → bit3=0.
- Stop mid-burst: clear run 10 bytes into a 128-byte burst → remaining 118 fr_valid counted, state returns IDLE, no further fr_go, af_rena=0.
- Reset mid-XFER: assert rst for 1 cycle → next cycle fr_go=0, busy=0, level=0, wb_rdata of CSR = 0.
